// File: rtl/gray_pkg.sv
// gray_pkg: shared types, defaults and window packing for the 3x3 window generator
package gray_pkg;
  localparam int PIX_W_DEF = 8;
  typedef logic [PIX_W_DEF-1:0] pix_t;
  typedef pix_t win_t [3][3];
  typedef enum logic {WAIT_SOF, RUN} state_t;
  function automatic logic [9*PIX_W_DEF-1:0] pack_win(input win_t w);
    logic [9*PIX_W_DEF-1:0] f;
    f = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        f[PIX_W_DEF*(3*r+c) +: PIX_W_DEF] = w[r][c];
    return f;
  endfunction
endpackage

// File: rtl/gray_line_ram.sv
// gray_line_ram: one image line of storage, synchronous write with asynchronous read
module gray_line_ram #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/gray_window_3x3.sv
// gray_window_3x3: streaming 3x3 neighbourhood generator over two buffered image lines
module gray_window_3x3
  import gray_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [PIX_W-1:0]   s_data,
  input  logic               s_sof,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [9*PIX_W-1:0] m_win,
  output logic               m_last,
  output logic               frame_err
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] XMAX = XW'(IMG_W-1);
  localparam logic [YW-1:0] YMAX = YW'(IMG_H-1);
  state_t state;
  logic [XW-1:0] x, px, nx;
  logic [YW-1:0] y, py, ny;
  logic [3*PIX_W-1:0] win_q [3];
  logic [3*PIX_W-1:0] win_n [3];
  logic [PIX_W-1:0] lb0_q, lb1_q;
  logic acc, proc, early, emit;
  assign s_ready = !m_valid || m_ready;
  // an s_sof pixel is always position (0,0), whether it starts, restarts or confirms a frame
  always_comb begin
    acc   = s_valid && s_ready;
    proc  = acc && (state == RUN || s_sof);
    early = s_sof && state == RUN && (x != '0 || y != '0);
    px    = s_sof ? '0 : x;
    py    = s_sof ? '0 : y;
    nx    = px == XMAX ? '0 : px + 1'b1;
    ny    = px != XMAX ? py : py == YMAX ? '0 : py + 1'b1;
    emit  = proc && px >= XW'(2) && py >= YW'(2);
    win_n[0] = {lb1_q,  win_q[0][3*PIX_W-1:PIX_W]};
    win_n[1] = {lb0_q,  win_q[1][3*PIX_W-1:PIX_W]};
    win_n[2] = {s_data, win_q[2][3*PIX_W-1:PIX_W]};
  end
  gray_line_ram #(.DEPTH(IMG_W), .WIDTH(PIX_W)) lb0 (
    .clk(clk), .we(proc), .addr(px), .wdata(s_data), .rdata(lb0_q)
  );
  gray_line_ram #(.DEPTH(IMG_W), .WIDTH(PIX_W)) lb1 (
    .clk(clk), .we(proc), .addr(px), .wdata(lb0_q), .rdata(lb1_q)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_SOF;
      x         <= '0;
      y         <= '0;
      win_q     <= '{default: '0};
      m_valid   <= 1'b0;
      m_win     <= '0;
      m_last    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= acc && early;
      if (proc) begin
        state <= RUN;
        x     <= nx;
        y     <= ny;
        win_q <= win_n;
      end
      if (emit) begin
        m_valid <= 1'b1;
        m_win   <= {win_n[2], win_n[1], win_n[0]};
        m_last  <= px == XMAX && py == YMAX;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_gray_window_3x3.sv
// tb_gray_window_3x3: scoreboard bench on a 4x4 image model
module tb_gray_window_3x3;
  localparam int W = 4, H = 4, P = 8;
  logic clk = 0, rst_n = 1, s_valid = 0, s_sof = 0, m_ready = 1;
  logic s_ready, m_valid, m_last, frame_err;
  logic [P-1:0] s_data = '0;
  logic [9*P-1:0] m_win;
  typedef struct {logic [9*P-1:0] win; logic last; time t;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  int mode = 0, pidx = 0, nwin = 0, nlast = 0, nerr = 0, exp_err = 0;
  logic [P-1:0] img [H][W];
  int mx = 0, my = 0;
  bit mrun = 0, seen = 0;
  time t_acc;

  gray_window_3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_sof(s_sof), .m_valid(m_valid), .m_ready(m_ready), .m_win(m_win),
    .m_last(m_last), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    m_ready = mode == 0 ? 1'b1 : mode == 2 ? 1'b0 : (pidx % 4 == 0 || pidx % 4 == 3);
    pidx++;
    #1;
    if (rst_n) begin
      total++;
      if (s_ready !== (!m_valid || m_ready)) begin
        bad++;
        $display("FAIL ready: s_ready=%b m_valid=%b m_ready=%b", s_ready, m_valid, m_ready);
      end
      if (frame_err) nerr++;
      if (m_valid) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL extra_window: got %h, none expected", m_win);
        end else begin
          if (m_win !== q[0].win || m_last !== q[0].last) begin
            bad++;
            $display("FAIL window: got %h last=%b, want %h last=%b", m_win, m_last, q[0].win, q[0].last);
          end
          if (!seen) begin
            total++;
            if ($time - 6 != q[0].t) begin
              bad++;
              $display("FAIL latency: visible at %0t, accept at %0t", $time, q[0].t);
            end
          end
          seen = 1;
          if (m_ready) begin
            if (q[0].last) nlast++;
            void'(q.pop_front());
            nwin++;
            seen = 0;
          end
        end
      end
    end
  end

  task automatic model(input logic [P-1:0] d, input bit sof);
    logic [9*P-1:0] w;
    if (!mrun && !sof) return;
    if (sof) begin
      if (mrun && (mx != 0 || my != 0)) exp_err++;
      mx = 0; my = 0; mrun = 1;
    end
    img[my][mx] = d;
    if (mx >= 2 && my >= 2) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w[P*(3*r+c) +: P] = img[my-2+r][mx-2+c];
      q.push_back('{w, mx == W-1 && my == H-1, t_acc});
    end
    mx++;
    if (mx == W) begin
      mx = 0;
      my = my == H-1 ? 0 : my + 1;
    end
  endtask

  task automatic send(input logic [P-1:0] d, input bit sof);
    int n = 0;
    @(negedge clk);
    s_valid = 1; s_data = d; s_sof = sof;
    #2;
    while (!s_ready && n < 100) begin
      @(negedge clk); #2; n++;
    end
    if (!s_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: s_ready=%b want 1", s_ready);
      s_valid = 0; s_sof = 0;
      return;
    end
    @(posedge clk);
    t_acc = $time;
    model(d, sof);
    #1 s_valid = 0; s_sof = 0;
  endtask

  task automatic send_frame(input logic [P-1:0] base);
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        send(base + P'(16*yy + xx), xx == 0 && yy == 0);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk); n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d windows pending, want 0", q.size());
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic clear_model();
    q.delete(); seen = 0; mrun = 0; mx = 0; my = 0;
    nwin = 0; nlast = 0; nerr = 0; exp_err = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic check_counts(input string nm, input int want_win, input int want_last);
    total++;
    if (nwin != want_win) begin bad++; $display("FAIL %s_windows: got %0d want %0d", nm, nwin, want_win); end
    total++;
    if (nlast != want_last) begin bad++; $display("FAIL %s_last: got %0d want %0d", nm, nlast, want_last); end
    total++;
    if (nerr != exp_err) begin bad++; $display("FAIL %s_frame_err: got %0d want %0d", nm, nerr, exp_err); end
  endtask

  task automatic test_reset();
    #2 rst_n = 0;
    #1;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
    total++; if (m_win !== '0) begin bad++; $display("FAIL rst_m_win: got %h want 0", m_win); end
    total++; if (m_last !== 1'b0) begin bad++; $display("FAIL rst_m_last: got %b want 0", m_last); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_frame_err: got %b want 0", frame_err); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rst_s_ready: got %b want 1", s_ready); end
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_basic();
    mode = 0; clear_model();
    send_frame(8'h00);
    drain();
    check_counts("basic", 4, 1);
  endtask

  task automatic test_stall();
    mode = 1; pidx = 0;
    nwin = 0; nlast = 0; nerr = 0; exp_err = 0;
    send_frame(8'h00);
    drain();
    check_counts("stall", 4, 1);
    mode = 0;
  endtask

  task automatic test_no_sof();
    do_reset();
    for (int i = 0; i < 5; i++) send(8'hA0 + P'(i), 0);
    send_frame(8'h00);
    drain();
    check_counts("no_sof", 4, 1);
  endtask

  task automatic test_early_sof();
    nwin = 0; nlast = 0; nerr = 0; exp_err = 0;
    for (int i = 0; i < 2*W + 1; i++) send(8'h80 + P'(16*(i/W) + i%W), i == 0);
    send_frame(8'h00);
    drain();
    check_counts("early_sof", 4, 1);
  endtask

  task automatic test_back_to_back();
    nwin = 0; nlast = 0; nerr = 0; exp_err = 0;
    send_frame(8'h00);
    send_frame(8'h40);
    drain();
    check_counts("b2b", 8, 2);
  endtask

  task automatic test_reset_stall();
    mode = 2;
    clear_model();
    for (int i = 0; i < 2*W + 3; i++) send(P'(16*(i/W) + i%W), i == 0);
    repeat (2) @(negedge clk);
    #3;
    total++;
    if (m_valid !== 1'b1) begin bad++; $display("FAIL stall_hold: m_valid=%b want 1", m_valid); end
    rst_n = 0;
    #1;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL async_rst_m_valid: got %b want 0", m_valid); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL async_rst_s_ready: got %b want 1", s_ready); end
    clear_model();
    mode = 0;
    @(negedge clk);
    rst_n = 1;
    send_frame(8'h10);
    drain();
    check_counts("after_rst", 4, 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_no_sof();
    test_early_sof();
    test_back_to_back();
    test_reset_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
endmodule
